laser500_loader: RTL and testbench
==================================

LASER500_LOADER -- requirements
Module: laser500_loader

Interface
REQ-001 SHALL expose parameter PRG_BASE, default 16'h8995: RAM load base for ioctl_index 1 (PRG).
REQ-002 SHALL expose parameter BIN_BASE, default 16'h8000: RAM load base for ioctl_index 2 (BIN).
REQ-003 SHALL expose parameter EOP_PTR_ADDR, default 16'h83E9: address of the little-endian BASIC end-of-program pointer.
REQ-004 SHALL expose parameter FIFO_DEPTH, default 4, power of two, minimum 4.
REQ-005 F14M  in  1  sole clock; all logic clocks on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 ioctl_download  in  1  download in progress, from hps_io.
REQ-008 ioctl_wr  in  1  one-cycle strobe; byte valid.
REQ-009 ioctl_addr  in  25  file byte offset.
REQ-010 ioctl_data  in  8  file byte.
REQ-011 ioctl_index  in  8  file type (1 = PRG, 2 = BIN).
REQ-012 ioctl_wait  out  1  throttle request to hps_io.
REQ-013 ram_addr  out  16  RAM write address.
REQ-014 ram_din  out  8  RAM write data.
REQ-015 ram_wr  out  1  write request, held until acknowledged.
REQ-016 ram_ack  in  1  write accepted by the RAM arbiter.
REQ-017 cpu_hold  out  1  holds the Z80 in reset while loading.
REQ-018 overflow_err  out  1  sticky: a byte was dropped.

Function
REQ-019 States SHALL be IDLE, LOAD, DRAIN, PTR_LO, PTR_HI and DONE.
REQ-020 IDLE -> LOAD on the cycle ioctl_download rises with ioctl_index equal to 1 or 2; base is latched; overflow_err and max address are cleared.
REQ-021 Other index values SHALL be ignored entirely: no RAM writes and no cpu_hold.
REQ-022 In LOAD, each ioctl_wr with ioctl_addr[24:16] equal to 0 SHALL push {base + ioctl_addr[15:0] (mod 2^16), ioctl_data} into the FIFO; bytes at addresses of 65536 or above are discarded silently.
REQ-023 FIFO full and ioctl_wr in the same cycle: byte dropped and overflow_err set; a simultaneous pop does not free a slot for that byte.
REQ-024 ioctl_wait SHALL be high when FIFO occupancy is at least FIFO_DEPTH-1, otherwise low (combinational from the registered count).
REQ-025 Write port: on a non-empty FIFO with no write pending, ram_wr rises next cycle with the head entry on ram_addr/ram_din.
REQ-026 ram_addr/ram_din SHALL stay stable while ram_wr is high; the entry pops in the cycle ram_ack is high; ram_wr deasserts the following cycle.
REQ-027 Minimum spacing between consecutive ram_wr assertions is 1 idle cycle.
REQ-028 ram_ack while ram_wr is low SHALL be ignored.
REQ-029 Loader SHALL track end = (highest accepted offset + 1) + base, mod 2^16.
REQ-030 LOAD -> DRAIN when ioctl_download falls; a strobe coincident with the fall is still accepted.
REQ-031 DRAIN -> PTR_LO when the FIFO is empty, no write is pending, and the index is 1; otherwise DRAIN -> DONE.
REQ-032 PTR_LO writes end[7:0] to EOP_PTR_ADDR; PTR_HI writes end[15:8] to EOP_PTR_ADDR+1; both use the REQ-026 handshake.
REQ-033 DONE lasts exactly 1 cycle, then -> IDLE.
REQ-034 cpu_hold SHALL be high in every state except IDLE, registered, and drop on the IDLE entry edge.
REQ-035 A download with zero accepted bytes SHALL write end = base.
REQ-036 ioctl_download rising outside IDLE SHALL be ignored until IDLE.

Reset
REQ-037 Asynchronous reset SHALL force state IDLE, FIFO empty, ram_wr=0, cpu_hold=0, ioctl_wait=0, overflow_err=0, ram_addr=0, ram_din=0.
REQ-038 Reset mid-handshake SHALL abandon the pending write; no pointer fix-up follows.

Configuration
REQ-039 Macro LASER500_LOADER_PTR_FIXUP_EN defined: PRG downloads perform PTR_LO/PTR_HI per REQ-031/032.
REQ-040 Macro undefined: DRAIN -> DONE for all indexes; PTR states, end tracking and EOP_PTR_ADDR logic are not synthesised.

Verification
REQ-041 PRG, 3 bytes 0x11,0x22,0x33, ram_ack 2 cycles after ram_wr -> writes 8995=11, 8996=22, 8997=33, then 83E9=98, 83EA=89; cpu_hold falls 1 cycle after DONE.
REQ-042 BIN, 2 bytes 0xAA,0xBB -> writes 8000=AA, 8001=BB, no pointer writes; overflow_err=0.
REQ-043 ram_ack held low for 20 cycles with strobes every 2 cycles -> ioctl_wait high at occupancy 3; sixth strobe into the full FIFO -> overflow_err=1 and no write of that byte.
REQ-044 Index 3 download of 10 bytes -> no ram_wr, cpu_hold stays 0.
REQ-045 Reset asserted while ram_wr is high during a PRG load -> all outputs 0 within the same cycle; no 83E9 write after release.
REQ-046 PRG with ioctl_addr 0x0FFFF and 0x10000 -> first byte written to 0x8994 (wrapped), second discarded; end pointer = 0x8995.

Source files
------------

// File: rtl/laser500_loader.sv
// Laser 500 download loader: buffers hps_io file bytes in a small FIFO and writes them into Z80 RAM.
// Define LASER500_LOADER_PTR_FIXUP_EN to patch the BASIC end-of-program pointer after PRG loads.
module laser500_loader #(
    parameter logic [15:0] PRG_BASE     = 16'h8995,
    parameter logic [15:0] BIN_BASE     = 16'h8000,
    parameter logic [15:0] EOP_PTR_ADDR = 16'h83E9,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        F14M,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_wr,
    input  logic        ram_ack,
    output logic        cpu_hold,
    output logic        overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, PTR_LO, PTR_HI, DONE} state_t;

    state_t        state;
    logic          download_q;
    logic [15:0]   base;
    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          start;
    logic          push_req;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [15:0]   push_addr;

    assign start     = ioctl_download && !download_q &&
                       (ioctl_index == 8'd1 || ioctl_index == 8'd2);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign push_req  = (state == LOAD) && ioctl_wr && (ioctl_addr[24:16] == 9'd0);
    assign push      = push_req && !fifo_full;
    // Only byte-stream writes retire FIFO entries; pointer writes never do.
    assign pop       = ((state == LOAD) || (state == DRAIN)) && ram_wr && ram_ack;
    assign push_addr = base + ioctl_addr[15:0];
    assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1));

    always_ff @(posedge F14M) begin
        if (push)
            fifo_mem[wr_ptr] <= {push_addr, ioctl_data};
    end

    always_ff @(posedge F14M or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LASER500_LOADER_PTR_FIXUP_EN
    logic        is_prg;
    logic        any_byte;
    logic [15:0] max_off;
    logic [15:0] end_addr;

    // Highest accepted file offset; end pointer is one past it, relative to the load base.
    always_ff @(posedge F14M or posedge reset) begin
        if (reset) begin
            is_prg   <= 1'b0;
            any_byte <= 1'b0;
            max_off  <= '0;
        end else if (state == IDLE && start) begin
            is_prg   <= (ioctl_index == 8'd1);
            any_byte <= 1'b0;
            max_off  <= '0;
        end else if (push && (!any_byte || ioctl_addr[15:0] > max_off)) begin
            any_byte <= 1'b1;
            max_off  <= ioctl_addr[15:0];
        end
    end

    assign end_addr = any_byte ? (base + max_off + 16'd1) : base;
`endif

    always_ff @(posedge F14M or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            download_q   <= 1'b0;
            base         <= '0;
            cpu_hold     <= 1'b0;
            overflow_err <= 1'b0;
            ram_wr       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
        end else begin
            download_q <= ioctl_download;
            if (push_req && fifo_full)
                overflow_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LOAD;
                        base         <= (ioctl_index == 8'd1) ? PRG_BASE : BIN_BASE;
                        overflow_err <= 1'b0;
                        cpu_hold     <= 1'b1;
                    end
                end

                LOAD, DRAIN: begin
                    if (ram_wr) begin
                        if (ram_ack)
                            ram_wr <= 1'b0;
                    end else if (count != '0) begin
                        ram_wr              <= 1'b1;
                        {ram_addr, ram_din} <= fifo_mem[rd_ptr];
                    end

                    if (state == LOAD) begin
                        if (!ioctl_download)
                            state <= DRAIN;
                    end else if (count == '0 && !ram_wr) begin
`ifdef LASER500_LOADER_PTR_FIXUP_EN
                        state <= is_prg ? PTR_LO : DONE;
`else
                        state <= DONE;
`endif
                    end
                end

`ifdef LASER500_LOADER_PTR_FIXUP_EN
                PTR_LO: begin
                    if (ram_wr) begin
                        if (ram_ack) begin
                            ram_wr <= 1'b0;
                            state  <= PTR_HI;
                        end
                    end else begin
                        ram_wr   <= 1'b1;
                        ram_addr <= EOP_PTR_ADDR;
                        ram_din  <= end_addr[7:0];
                    end
                end

                PTR_HI: begin
                    if (ram_wr) begin
                        if (ram_ack) begin
                            ram_wr <= 1'b0;
                            state  <= DONE;
                        end
                    end else begin
                        ram_wr   <= 1'b1;
                        ram_addr <= EOP_PTR_ADDR + 16'd1;
                        ram_din  <= end_addr[15:8];
                    end
                end
`endif

                DONE: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                    ram_wr   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_laser500_loader.sv
// Directed bench for laser500_loader: models the RAM arbiter and checks each load scenario.
module tb_laser500_loader;
    logic        F14M = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic        ram_ack = 1'b0;
    logic        cpu_hold;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int ack_delay = 2;
    int last_ack_edge = 0;
    bit ack_en = 1'b1;
    bit hold_seen = 1'b0;
    bit wr_seen = 1'b0;
    logic [15:0] held_addr;
    logic [7:0]  held_din;
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];

    laser500_loader dut (
        .F14M(F14M), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_wr(ram_wr), .ram_ack(ram_ack), .cpu_hold(cpu_hold), .overflow_err(overflow_err)
    );

    always #5 F14M = ~F14M;

    always @(posedge F14M) cyc++;

    // RAM arbiter model: acknowledges ack_delay cycles after ram_wr and logs each accepted write.
    always @(negedge F14M) begin
        if (cpu_hold === 1'b1) hold_seen = 1'b1;
        if (ram_wr === 1'b1) wr_seen = 1'b1;
        if (reset || ram_wr !== 1'b1) begin
            ram_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            if (ack_cnt == 0) begin
                held_addr = ram_addr;
                held_din  = ram_din;
            end else begin
                checks++;
                if (ram_addr !== held_addr || ram_din !== held_din) begin
                    errors++;
                    $display("[TB] FAIL stable_write: addr/data %h/%h, required %h/%h",
                             ram_addr, ram_din, held_addr, held_din);
                end
            end
            ack_cnt++;
            if (ack_en && ack_cnt >= ack_delay && !ram_ack) begin
                ram_ack = 1'b1;
                wr_addr_q.push_back(ram_addr);
                wr_data_q.push_back(ram_din);
                last_ack_edge = cyc + 1;
            end else begin
                ram_ack = 1'b0;
            end
        end
    end

    task automatic start_dl(input logic [7:0] idx);
        @(negedge F14M);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge F14M);
    endtask

    task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input bit honor_wait);
        int guard = 0;
        while (honor_wait && ioctl_wait === 1'b1 && guard < 200) begin
            @(negedge F14M);
            guard++;
        end
        if (honor_wait) begin
            checks++;
            if (guard >= 200) begin
                errors++;
                $display("[TB] FAIL wait_timeout: ioctl_wait %b after %0d cycles, required 0", ioctl_wait, guard);
            end
        end
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge F14M);
        ioctl_wr   = 1'b0;
        @(negedge F14M);
    endtask

    task automatic wait_idle(output int gap);
        int guard = 0;
        gap = -1;
        while (cpu_hold !== 1'b0 && guard < 500) begin
            @(negedge F14M);
            guard++;
        end
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_timeout: cpu_hold %b after %0d cycles, required 0", cpu_hold, guard);
        end else begin
            gap = cyc - last_ack_edge;
        end
    endtask

    task automatic clear_log;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge F14M);
        checks += 6;
        if (ram_wr !== 1'b0)        begin errors++; $display("[TB] FAIL reset_ram_wr: %b, required 0", ram_wr); end
        if (cpu_hold !== 1'b0)      begin errors++; $display("[TB] FAIL reset_cpu_hold: %b, required 0", cpu_hold); end
        if (ioctl_wait !== 1'b0)    begin errors++; $display("[TB] FAIL reset_ioctl_wait: %b, required 0", ioctl_wait); end
        if (overflow_err !== 1'b0)  begin errors++; $display("[TB] FAIL reset_overflow: %b, required 0", overflow_err); end
        if (ram_addr !== 16'h0000)  begin errors++; $display("[TB] FAIL reset_ram_addr: %h, required 0000", ram_addr); end
        if (ram_din !== 8'h00)      begin errors++; $display("[TB] FAIL reset_ram_din: %h, required 00", ram_din); end
        reset = 1'b0;
        repeat (2) @(negedge F14M);
    endtask

    task automatic test_prg_load;
        logic [15:0] ea [5] = '{16'h8995, 16'h8996, 16'h8997, 16'h83E9, 16'h83EA};
        logic [7:0]  ed [5] = '{8'h11, 8'h22, 8'h33, 8'h98, 8'h89};
        int n;
        int exp_gap;
        int gap;
`ifdef LASER500_LOADER_PTR_FIXUP_EN
        n = 5; exp_gap = 1;
`else
        n = 3; exp_gap = 2;
`endif
        clear_log();
        start_dl(8'd1);
        applyStimulus(25'h0, 8'h11, 1'b1);
        applyStimulus(25'h1, 8'h22, 1'b1);
        applyStimulus(25'h2, 8'h33, 1'b1);
        ioctl_download = 1'b0;
        wait_idle(gap);
        checks++;
        if (wr_addr_q.size() != n) begin
            errors++;
            $display("[TB] FAIL prg_write_count: %0d, required %0d", wr_addr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                errors++;
                $display("[TB] FAIL prg_write%0d: %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (gap != exp_gap) begin
            errors++;
            $display("[TB] FAIL prg_hold_release: %0d cycles after last ack, required %0d", gap, exp_gap);
        end
    endtask

    task automatic test_bin_load;
        logic [15:0] ea [2] = '{16'h8000, 16'h8001};
        logic [7:0]  ed [2] = '{8'hAA, 8'hBB};
        int gap;
        clear_log();
        start_dl(8'd2);
        applyStimulus(25'h0, 8'hAA, 1'b1);
        applyStimulus(25'h1, 8'hBB, 1'b1);
        ioctl_download = 1'b0;
        wait_idle(gap);
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL bin_write_count: %0d, required 2", wr_addr_q.size());
        end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                errors++;
                $display("[TB] FAIL bin_write%0d: %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bin_overflow: %b, required 0", overflow_err);
        end
    endtask

    task automatic test_overflow;
        int gap;
        clear_log();
        ack_en = 1'b0;
        start_dl(8'd2);
        applyStimulus(25'h0, 8'h01, 1'b0);
        applyStimulus(25'h1, 8'h02, 1'b0);
        checks++;
        if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL wait_at_2: %b, required 0", ioctl_wait); end
        applyStimulus(25'h2, 8'h03, 1'b0);
        checks++;
        if (ioctl_wait !== 1'b1) begin errors++; $display("[TB] FAIL wait_at_3: %b, required 1", ioctl_wait); end
        applyStimulus(25'h3, 8'h04, 1'b0);
        checks++;
        if (ioctl_wait !== 1'b1) begin errors++; $display("[TB] FAIL wait_at_4: %b, required 1", ioctl_wait); end
        applyStimulus(25'h4, 8'h05, 1'b0);
        applyStimulus(25'h5, 8'h06, 1'b0);
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: %b, required 1", overflow_err); end
        repeat (8) @(negedge F14M);
        ack_en = 1'b1;
        ioctl_download = 1'b0;
        wait_idle(gap);
        checks++;
        if (wr_addr_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL overflow_write_count: %0d, required 4", wr_addr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 16'h8000 + 16'(i) || wr_data_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("[TB] FAIL overflow_write%0d: %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i],
                         16'h8000 + 16'(i), 8'(i + 1));
            end
        end
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: %b, required 1", overflow_err); end
    endtask

    task automatic test_index3;
        clear_log();
        hold_seen = 1'b0;
        wr_seen   = 1'b0;
        start_dl(8'd3);
        for (int i = 0; i < 10; i++)
            applyStimulus(25'(i), 8'(8'h40 + i), 1'b1);
        ioctl_download = 1'b0;
        repeat (10) @(negedge F14M);
        checks += 2;
        if (wr_seen !== 1'b0)   begin errors++; $display("[TB] FAIL index3_ram_wr: seen %b, required 0", wr_seen); end
        if (hold_seen !== 1'b0) begin errors++; $display("[TB] FAIL index3_cpu_hold: seen %b, required 0", hold_seen); end
    endtask

    task automatic test_wrap;
        logic [15:0] ea [3] = '{16'h8994, 16'h83E9, 16'h83EA};
        logic [7:0]  ed [3] = '{8'h5A, 8'h95, 8'h89};
        int n;
        int gap;
`ifdef LASER500_LOADER_PTR_FIXUP_EN
        n = 3;
`else
        n = 1;
`endif
        clear_log();
        start_dl(8'd1);
        applyStimulus(25'h0FFFF, 8'h5A, 1'b1);
        applyStimulus(25'h10000, 8'hA5, 1'b1);
        ioctl_download = 1'b0;
        wait_idle(gap);
        checks++;
        if (wr_addr_q.size() != n) begin
            errors++;
            $display("[TB] FAIL wrap_write_count: %0d, required %0d", wr_addr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                errors++;
                $display("[TB] FAIL wrap_write%0d: %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_empty_prg;
        logic [15:0] ea [2] = '{16'h83E9, 16'h83EA};
        logic [7:0]  ed [2] = '{8'h95, 8'h89};
        int n;
        int gap;
`ifdef LASER500_LOADER_PTR_FIXUP_EN
        n = 2;
`else
        n = 0;
`endif
        clear_log();
        start_dl(8'd1);
        ioctl_download = 1'b0;
        wait_idle(gap);
        checks++;
        if (wr_addr_q.size() != n) begin
            errors++;
            $display("[TB] FAIL empty_write_count: %0d, required %0d", wr_addr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                errors++;
                $display("[TB] FAIL empty_write%0d: %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        clear_log();
        start_dl(8'd1);
        applyStimulus(25'h0, 8'h77, 1'b1);
        while (ram_wr !== 1'b1 && guard < 20) begin
            @(negedge F14M);
            guard++;
        end
        checks++;
        if (ram_wr !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ram_wr_rise: %b, required 1", ram_wr); end
        #2 reset = 1'b1;
        #1;
        checks += 6;
        if (ram_wr !== 1'b0)       begin errors++; $display("[TB] FAIL midreset_ram_wr: %b, required 0", ram_wr); end
        if (cpu_hold !== 1'b0)     begin errors++; $display("[TB] FAIL midreset_cpu_hold: %b, required 0", cpu_hold); end
        if (ioctl_wait !== 1'b0)   begin errors++; $display("[TB] FAIL midreset_ioctl_wait: %b, required 0", ioctl_wait); end
        if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_overflow: %b, required 0", overflow_err); end
        if (ram_addr !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_ram_addr: %h, required 0000", ram_addr); end
        if (ram_din !== 8'h00)     begin errors++; $display("[TB] FAIL midreset_ram_din: %h, required 00", ram_din); end
        ioctl_download = 1'b0;
        @(negedge F14M);
        reset = 1'b0;
        repeat (40) @(negedge F14M);
        checks += 2;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_writes_after: %0d writes, first %h, required 0", wr_addr_q.size(), wr_addr_q[0]);
        end
        if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL midreset_hold_after: %b, required 0", cpu_hold); end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_index    = '0;
        test_reset();
        test_prg_load();
        test_bin_load();
        test_overflow();
        test_index3();
        test_wrap();
        test_empty_prg();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
